pixie_dma_sched: RTL and testbench
==================================

PIXIE_DMA_SCHED -- requirements
Module: pixie_dma_sched

Interface
REQ-001 Parameter BASE_ADDR, 16'h0900: first display-RAM byte fetched each frame.
REQ-002 Parameter BYTES_PER_LINE, 8: DMA bytes per active scanline.
REQ-003 Parameter LINE_REPEAT, 4: scanlines per display row, each reusing the same 8 addresses.
REQ-004 Parameter LINES_PER_FRAME, 262; FIRST_ACTIVE, 64; LAST_ACTIVE, 191; INT_LINE, 62.
REQ-005 Port clk, input, 1: video/bus clock; reset, input, 1: synchronous, active-high.
REQ-006 Port clk_enable, input, 1: CDP1802 bus-cycle qualifier.
REQ-007 Port SC, input, 2: CPU state code; 2'b10 = DMA cycle.
REQ-008 Port line_start, input, 1: one-clk pulse at the start of each scanline from video timing.
REQ-009 Port frame_start, input, 1: one-clk pulse at line 0.
REQ-010 Port disp_on / disp_off, input, 1 each: I/O-decoded display enable/disable strobes.
REQ-011 Port DMAO, output, 1: active-low DMA-out request to CPU.
REQ-012 Port INT, output, 1: active-high display interrupt; EFx, output, 1: active-low frame flag.
REQ-013 Port dma_addr, output, 16: address of the byte currently being transferred.
REQ-014 Port byte_valid, output, 1: one-clk strobe per accepted DMA byte; byte_last, output, 1: marks the 8th byte.
REQ-015 Port display_enabled, output, 1: enable state; underrun, output, 1: sticky burst-overrun flag.

Function
REQ-016 States: IDLE, WAIT_LINE, REQ, DONE; reset enters IDLE.
REQ-017 display_enabled: set on clk_enable&disp_on, cleared on clk_enable&disp_off; both together -> cleared.
REQ-018 line_cnt (9 bit): +1 per line_start, wraps LINES_PER_FRAME-1 -> 0; frame_start forces 0 and wins over line_start.
REQ-019 IDLE -> WAIT_LINE when display_enabled=1; any state -> IDLE the cycle after display_enabled=0.
REQ-020 WAIT_LINE -> REQ on line_start whose new line_cnt is within FIRST_ACTIVE..LAST_ACTIVE.
REQ-021 In REQ, DMAO=0; ack = clk_enable & SC==2'b10; each ack pulses byte_valid with dma_addr = BASE_ADDR + row*8 + byte_cnt, then byte_cnt +1.
REQ-022 On the 8th ack, byte_last=1 with byte_valid, DMAO returns to 1 the next cycle, state -> DONE.
REQ-023 DONE: rep_cnt +1; at rep_cnt wrap (LINE_REPEAT) row +1, row 31 -> 0 (256-byte window); state -> WAIT_LINE.
REQ-024 line_start while in REQ: set underrun, discard remaining bytes, byte_cnt=0, apply DONE accounting, restart REQ if the new line is active.
REQ-025 frame_start clears row, rep_cnt and byte_cnt; underrun is cleared only by reset.
REQ-026 INT=1 for line_cnt INT_LINE..FIRST_ACTIVE-1 while display_enabled, else 0.
REQ-027 EFx=0 for lines FIRST_ACTIVE-4..FIRST_ACTIVE-1 and LAST_ACTIVE-3..LAST_ACTIVE, else 1.
REQ-028 DMAO=1 outside REQ; no ack outside REQ produces byte_valid.
REQ-029 All outputs registered; latency ack -> byte_valid is one clk.

Reset
REQ-030 Reset: state IDLE, line_cnt/row/rep_cnt/byte_cnt 0, DMAO=1, INT=0, EFx=1, byte_valid=0, byte_last=0, dma_addr=BASE_ADDR, display_enabled=0, underrun=0.
REQ-031 Reset mid-burst takes effect the next clk regardless of clk_enable; DMAO is 1 that cycle.

Structure
REQ-032 Frame-geometry constants (LINES_PER_FRAME, FIRST_ACTIVE, LAST_ACTIVE, INT_LINE, BASE_ADDR) and the state encoding live in the shared package pixie_pkg.
REQ-033 One sub-module, pixie_line_counter (line_cnt plus active/INT/EF decode); the FSM and address generator stay in the top module.

Verification
REQ-034 Enable, frame_start, 64 line_starts, then 8 acks -> DMAO falls on line 64; dma_addr 0x0900..0x0907; byte_last on 0x0907; DMAO=1.
REQ-035 Lines 64..67 fully acked, then line 68 -> addresses repeat 0x0900..0x0907 four times; line 68 starts at 0x0908.
REQ-036 Full 262-line frame -> INT high lines 62-63 only; EFx low on lines 60-63 and 188-191; row wraps to 0x0900 at the next frame.
REQ-037 line_start after only 3 acks -> underrun=1; the next burst starts at byte 0 of the correct row.
REQ-038 disp_on and disp_off in the same clk_enable cycle mid-burst -> display_enabled=0, DMAO=1 the next cycle, no further byte_valid.
REQ-039 reset asserted after the 5th ack -> next clk all outputs at REQ-030 values.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared frame geometry, state encoding and line-window helper for the pixie DMA scheduler.
package pixie_pkg;

  localparam logic [15:0] PIXIE_BASE_ADDR       = 16'h0900;
  localparam int          PIXIE_BYTES_PER_LINE  = 8;
  localparam int          PIXIE_LINE_REPEAT     = 4;
  localparam int          PIXIE_LINES_PER_FRAME = 262;
  localparam int          PIXIE_FIRST_ACTIVE    = 64;
  localparam int          PIXIE_LAST_ACTIVE     = 191;
  localparam int          PIXIE_INT_LINE        = 62;

  localparam int LINE_W = 9;
  localparam int ROW_W  = 5;

  localparam logic [1:0] SC_DMA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_REQ,
    ST_DONE
  } state_t;

  function automatic logic in_window(input logic [LINE_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/pixie_line_counter.sv
// Scanline counter with look-ahead decode of the active window, interrupt zone and frame flag.
module pixie_line_counter
  import pixie_pkg::*;
#(
  parameter int LINES_PER_FRAME = PIXIE_LINES_PER_FRAME,
  parameter int FIRST_ACTIVE    = PIXIE_FIRST_ACTIVE,
  parameter int LAST_ACTIVE     = PIXIE_LAST_ACTIVE,
  parameter int INT_LINE        = PIXIE_INT_LINE
) (
  input  logic clk,
  input  logic reset,
  input  logic line_start,
  input  logic frame_start,
  output logic next_active,
  output logic next_int_zone,
  output logic ef_n
);

  logic [LINE_W-1:0] line_cnt;
  logic [LINE_W-1:0] next_line;
  logic              next_ef_zone;

  // Decodes look at the value line_cnt is about to take, so registered users line up with it.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_line = line_cnt;
    if (frame_start) begin
      next_line = '0;
    end else if (line_start) begin
      next_line = (line_cnt == LINE_W'(LINES_PER_FRAME - 1)) ? '0 : line_cnt + 1'b1;
    end
    next_active   = in_window(next_line, FIRST_ACTIVE, LAST_ACTIVE);
    next_int_zone = in_window(next_line, INT_LINE, FIRST_ACTIVE - 1);
    next_ef_zone  = in_window(next_line, FIRST_ACTIVE - 4, FIRST_ACTIVE - 1) ||
                    in_window(next_line, LAST_ACTIVE - 3, LAST_ACTIVE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt <= '0;
      ef_n     <= 1'b1;
    end else begin
      line_cnt <= next_line;
      ef_n     <= ~next_ef_zone;
    end
  end

endmodule

// File: rtl/pixie_dma_sched.sv
// CDP1861-style display DMA scheduler: requests one 8-byte burst per active scanline,
// repeating each display row over several lines, with interrupt and frame-flag timing.
module pixie_dma_sched
  import pixie_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR       = PIXIE_BASE_ADDR,
  parameter int          BYTES_PER_LINE  = PIXIE_BYTES_PER_LINE,
  parameter int          LINE_REPEAT     = PIXIE_LINE_REPEAT,
  parameter int          LINES_PER_FRAME = PIXIE_LINES_PER_FRAME,
  parameter int          FIRST_ACTIVE    = PIXIE_FIRST_ACTIVE,
  parameter int          LAST_ACTIVE     = PIXIE_LAST_ACTIVE,
  parameter int          INT_LINE        = PIXIE_INT_LINE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  SC,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic        disp_on,
  input  logic        disp_off,
  output logic        DMAO,
  output logic        INT,
  output logic        EFx,
  output logic [15:0] dma_addr,
  output logic        byte_valid,
  output logic        byte_last,
  output logic        display_enabled,
  output logic        underrun
);

  localparam int BC_W  = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam int REP_W = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES_PER_LINE - 1);
  localparam logic [REP_W-1:0] LAST_REP  = REP_W'(LINE_REPEAT - 1);

  state_t             state;
  logic [BC_W-1:0]    byte_cnt;
  logic [REP_W-1:0]   rep_cnt;
  logic [ROW_W-1:0]   row;
  logic [REP_W-1:0]   rep_after;
  logic [ROW_W-1:0]   row_after;
  logic [15:0]        cur_addr;
  logic               de_next;
  logic               ack;
  logic               next_active;
  logic               next_int_zone;

  pixie_line_counter #(
    .LINES_PER_FRAME (LINES_PER_FRAME),
    .FIRST_ACTIVE    (FIRST_ACTIVE),
    .LAST_ACTIVE     (LAST_ACTIVE),
    .INT_LINE        (INT_LINE)
  ) u_line_counter (
    .clk           (clk),
    .reset         (reset),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .next_active   (next_active),
    .next_int_zone (next_int_zone),
    .ef_n          (EFx)
  );

  // Disable wins when both strobes land in the same bus cycle; the row pointer wraps in 5 bits.
  always_comb begin
    de_next = display_enabled;
    if (clk_enable && disp_off) begin
      de_next = 1'b0;
    end else if (clk_enable && disp_on) begin
      de_next = 1'b1;
    end
    ack       = clk_enable && (SC == SC_DMA);
    rep_after = (rep_cnt == LAST_REP) ? '0 : rep_cnt + 1'b1;
    row_after = (rep_cnt == LAST_REP) ? row + 1'b1 : row;
    cur_addr  = BASE_ADDR + 16'(row) * 16'(BYTES_PER_LINE) + 16'(byte_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      byte_cnt        <= '0;
      rep_cnt         <= '0;
      row             <= '0;
      DMAO            <= 1'b1;
      INT             <= 1'b0;
      byte_valid      <= 1'b0;
      byte_last       <= 1'b0;
      dma_addr        <= BASE_ADDR;
      display_enabled <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      display_enabled <= de_next;
      INT             <= next_int_zone && de_next;
      byte_valid      <= 1'b0;
      byte_last       <= 1'b0;

      if (!display_enabled) begin
        state    <= ST_IDLE;
        DMAO     <= 1'b1;
        byte_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_WAIT_LINE;

          ST_WAIT_LINE: begin
            if (line_start && next_active) begin
              state <= ST_REQ;
              DMAO  <= 1'b0;
            end
          end

          ST_REQ: begin
            if (line_start) begin
              // Burst overran its line: drop the rest and account the line as if completed.
              underrun <= 1'b1;
              byte_cnt <= '0;
              rep_cnt  <= rep_after;
              row      <= row_after;
              state    <= next_active ? ST_REQ : ST_WAIT_LINE;
              DMAO     <= ~next_active;
            end else if (ack && de_next) begin
              byte_valid <= 1'b1;
              dma_addr   <= cur_addr;
              byte_last  <= (byte_cnt == LAST_BYTE);
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
                DMAO     <= 1'b1;
                state    <= ST_DONE;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end

          ST_DONE: begin
            rep_cnt <= rep_after;
            row     <= row_after;
            if (line_start && next_active) begin
              state <= ST_REQ;
              DMAO  <= 1'b0;
            end else begin
              state <= ST_WAIT_LINE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end

      if (frame_start) begin
        row      <= '0;
        rep_cnt  <= '0;
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pixie_dma_sched.sv
// Directed bench for pixie_dma_sched: frame timing, burst addressing, underrun, disable and reset.
module tb_pixie_dma_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [1:0]  SC;
  logic        line_start;
  logic        frame_start;
  logic        disp_on;
  logic        disp_off;
  logic        DMAO;
  logic        INT;
  logic        EFx;
  logic [15:0] dma_addr;
  logic        byte_valid;
  logic        byte_last;
  logic        display_enabled;
  logic        underrun;

  int tests = 0;
  int fails = 0;
  logic exp_ur = 1'b0;

  always #5 clk = ~clk;

  pixie_dma_sched dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .SC              (SC),
    .line_start      (line_start),
    .frame_start     (frame_start),
    .disp_on         (disp_on),
    .disp_off        (disp_off),
    .DMAO            (DMAO),
    .INT             (INT),
    .EFx             (EFx),
    .dma_addr        (dma_addr),
    .byte_valid      (byte_valid),
    .byte_last       (byte_last),
    .display_enabled (display_enabled),
    .underrun        (underrun)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic ack();
    SC = 2'b10;
    tick();
    SC = 2'b00;
  endtask

  task automatic check_reset_values(input string tag);
    check1 ({tag, ".DMAO"}, DMAO, 1'b1);
    check1 ({tag, ".INT"}, INT, 1'b0);
    check1 ({tag, ".EFx"}, EFx, 1'b1);
    check1 ({tag, ".byte_valid"}, byte_valid, 1'b0);
    check1 ({tag, ".byte_last"}, byte_last, 1'b0);
    check16({tag, ".dma_addr"}, dma_addr, 16'h0900);
    check1 ({tag, ".display_enabled"}, display_enabled, 1'b0);
    check1 ({tag, ".underrun"}, underrun, 1'b0);
  endtask

  // Advance to line k, check its timing flags, then serve n_acks bytes if the line is active.
  task automatic line_step(input int k, input int n_acks);
    logic        active;
    logic [15:0] base;
    active = (k >= 64) && (k <= 191);
    base   = 16'h0900 + 16'(((k - 64) / 4) * 8);
    pulse_line();
    check1($sformatf("INT@%0d", k), INT, (k >= 62) && (k <= 63));
    check1($sformatf("EFx@%0d", k), EFx, !(((k >= 60) && (k <= 63)) || ((k >= 188) && (k <= 191))));
    check1($sformatf("DMAO@%0d", k), DMAO, !active);
    check1($sformatf("underrun@%0d", k), underrun, exp_ur);
    if (active) begin
      for (int i = 0; i < n_acks; i++) begin
        ack();
        check1 ($sformatf("valid@%0d.%0d", k, i), byte_valid, 1'b1);
        check16($sformatf("addr@%0d.%0d", k, i), dma_addr, base + 16'(i));
        check1 ($sformatf("last@%0d.%0d", k, i), byte_last, i == 7);
      end
      if (n_acks == 8) begin
        check1($sformatf("DMAO_end@%0d", k), DMAO, 1'b1);
        ack();
        check1($sformatf("stray@%0d", k), byte_valid, 1'b0);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    clk_enable  = 1'b1;
    SC          = 2'b00;
    line_start  = 1'b0;
    frame_start = 1'b0;
    disp_on     = 1'b0;
    disp_off    = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    disp_on = 1'b1;
    tick();
    disp_on = 1'b0;
    check1("enable", display_enabled, 1'b1);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;

    // Frame 1: full bursts everywhere except line 69, which is cut short after 3 bytes.
    for (int k = 1; k < 262; k++) begin
      if (k == 70) exp_ur = 1'b1;
      line_step(k, (k == 69) ? 3 : 8);
    end

    // Frame 2 arrives by counter wrap; the row pointer has wrapped back to the base.
    for (int k = 0; k < 64; k++) line_step(k, 0);
    line_step(64, 2);

    // Enable and disable together mid-burst: disable wins and the burst is abandoned.
    disp_on  = 1'b1;
    disp_off = 1'b1;
    tick();
    disp_on  = 1'b0;
    disp_off = 1'b0;
    check1("both_strobes.display_enabled", display_enabled, 1'b0);
    tick();
    check1("both_strobes.DMAO", DMAO, 1'b1);
    ack();
    check1("after_disable.valid0", byte_valid, 1'b0);
    ack();
    check1("after_disable.valid1", byte_valid, 1'b0);
    check1("after_disable.INT", INT, 1'b0);

    // Re-enable, start a fresh frame, then reset in the middle of a burst.
    disp_on = 1'b1;
    tick();
    disp_on = 1'b0;
    check1("reenable", display_enabled, 1'b1);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 1; k <= 64; k++) pulse_line();
    check1("f3.DMAO@64", DMAO, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ack();
      check16($sformatf("f3.addr.%0d", i), dma_addr, 16'h0900 + 16'(i));
    end
    reset      = 1'b1;
    clk_enable = 1'b0;
    SC         = 2'b10;
    tick();
    check_reset_values("midburst_reset");
    reset      = 1'b0;
    SC         = 2'b00;
    clk_enable = 1'b1;
    tick();
    check1("post_reset.DMAO", DMAO, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
